id_ex_stage: RTL and testbench

- Decode-to-execute pipeline register. It produces the operand and control bundle that the execute stage consumes: r1, r2, Imm, ALUOp, ALUSrc1, ALUSrc2, PCp and b_control.
- Sits between the decode/register-file block and IE.
- Forwards late write-back results into the captured operands.
- Detects load-use hazards and inserts bubbles.
- Takes the branch decision (b_sel) back from IE as a flush.

---
 rtl/id_ex_stage.sv | 153 +++++++++++++++
 tb/tb_id_ex_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with write-back forwarding, load-use bubbles and branch flush.
// Optional macro IDEX_FWD_EN enables operand forwarding; without it any RAW match stalls instead.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_r1,
  input  logic [XLEN-1:0] id_r2,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic [REGW-1:0] id_rd,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_pcp,
  input  logic [3:0]      id_aluop,
  input  logic            id_alusrc1,
  input  logic            id_alusrc2,
  input  logic [2:0]      id_b_control,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            exm_regwrite,
  input  logic [REGW-1:0] exm_rd,
  input  logic [XLEN-1:0] exm_result,
  input  logic            mwb_regwrite,
  input  logic [REGW-1:0] mwb_rd,
  input  logic [XLEN-1:0] mwb_result,
  input  logic            stall_in,
  input  logic            b_sel,
  output logic            hazard_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] r1,
  output logic [XLEN-1:0] r2,
  output logic [XLEN-1:0] Imm,
  output logic [XLEN-1:0] PCp,
  output logic [3:0]      ALUOp,
  output logic            ALUSrc1,
  output logic            ALUSrc2,
  output logic [2:0]      b_control,
  output logic [REGW-1:0] ex_rd,
  output logic            ex_regwrite,
  output logic            ex_memread
);

  // Handshake: ex_valid marks a real instruction in EX; stall_in holds everything,
  // hazard_stall tells IF/ID to hold while this stage emits a bubble.
  typedef enum logic [1:0] {
    UPD_CLEAR,
    UPD_BUBBLE,
    UPD_HOLD,
    UPD_LOAD
  } upd_e;

  upd_e            upd;
  logic            load_use;
  logic [XLEN-1:0] r1_next;
  logic [XLEN-1:0] r2_next;

  function automatic logic raw_match(input logic we, input logic [REGW-1:0] rd,
                                     input logic [REGW-1:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

  assign load_use = id_valid & ex_valid & ex_memread & (ex_rd != '0) &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));

`ifdef IDEX_FWD_EN
  assign hazard_stall = load_use;

  // EX/MEM is the newer result, so it is checked first.
  always_comb begin
    r1_next = id_r1;
    r2_next = id_r2;
    if (raw_match(exm_regwrite, exm_rd, id_rs1))      r1_next = exm_result;
    else if (raw_match(mwb_regwrite, mwb_rd, id_rs1)) r1_next = mwb_result;
    if (raw_match(exm_regwrite, exm_rd, id_rs2))      r2_next = exm_result;
    else if (raw_match(mwb_regwrite, mwb_rd, id_rs2)) r2_next = mwb_result;
  end
`else
  logic raw_any;
  logic unused_results;

  assign raw_any = raw_match(ex_valid & ex_regwrite, ex_rd, id_rs1) |
                   raw_match(ex_valid & ex_regwrite, ex_rd, id_rs2) |
                   raw_match(exm_regwrite, exm_rd, id_rs1) |
                   raw_match(exm_regwrite, exm_rd, id_rs2) |
                   raw_match(mwb_regwrite, mwb_rd, id_rs1) |
                   raw_match(mwb_regwrite, mwb_rd, id_rs2);

  assign hazard_stall   = load_use | (id_valid & raw_any);
  assign r1_next        = id_r1;
  assign r2_next        = id_r2;
  assign unused_results = ^{exm_result, mwb_result};
`endif

  // A branch flush outranks a downstream hold: the held bundle is on the wrong path.
  always_comb begin
    upd = UPD_LOAD;
    if (rst)               upd = UPD_CLEAR;
    else if (b_sel)        upd = UPD_BUBBLE;
    else if (stall_in)     upd = UPD_HOLD;
    else if (hazard_stall) upd = UPD_BUBBLE;
  end

  always_ff @(posedge clk) begin
    case (upd)
      UPD_CLEAR, UPD_BUBBLE: begin
        ex_valid    <= 1'b0;
        r1          <= '0;
        r2          <= '0;
        Imm         <= '0;
        PCp         <= '0;
        ALUOp       <= 4'b0000;
        ALUSrc1     <= 1'b0;
        ALUSrc2     <= 1'b0;
        b_control   <= 3'b000;
        ex_rd       <= '0;
        ex_regwrite <= 1'b0;
        ex_memread  <= 1'b0;
      end
      UPD_LOAD: begin
        ex_valid    <= id_valid;
        r1          <= r1_next;
        r2          <= r2_next;
        Imm         <= id_imm;
        PCp         <= id_pcp;
        ALUOp       <= id_aluop;
        ALUSrc1     <= id_alusrc1;
        ALUSrc2     <= id_alusrc2;
        b_control   <= id_b_control;
        ex_rd       <= id_rd;
        ex_regwrite <= id_regwrite;
        ex_memread  <= id_memread;
      end
      default: begin
        ex_valid    <= ex_valid;
        r1          <= r1;
        r2          <= r2;
        Imm         <= Imm;
        PCp         <= PCp;
        ALUOp       <= ALUOp;
        ALUSrc1     <= ALUSrc1;
        ALUSrc2     <= ALUSrc2;
        b_control   <= b_control;
        ex_rd       <= ex_rd;
        ex_regwrite <= ex_regwrite;
        ex_memread  <= ex_memread;
      end
    endcase
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, capture, forwarding or RAW stalls, load-use, flush, hold.
module tb_id_ex_stage;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_r1, id_r2, id_imm, id_pcp;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_aluop;
  logic        id_alusrc1, id_alusrc2;
  logic [2:0]  id_b_control;
  logic        id_regwrite, id_memread;
  logic        exm_regwrite, mwb_regwrite;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_result, mwb_result;
  logic        stall_in, b_sel;
  logic        hazard_stall, ex_valid;
  logic [31:0] r1, r2, Imm, PCp;
  logic [3:0]  ALUOp;
  logic        ALUSrc1, ALUSrc2;
  logic [2:0]  b_control;
  logic [4:0]  ex_rd;
  logic        ex_regwrite, ex_memread;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  id_ex_stage #(.XLEN(32), .REGW(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_r1(id_r1), .id_r2(id_r2), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_imm(id_imm), .id_pcp(id_pcp), .id_aluop(id_aluop),
    .id_alusrc1(id_alusrc1), .id_alusrc2(id_alusrc2), .id_b_control(id_b_control),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_regwrite(mwb_regwrite), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
    .stall_in(stall_in), .b_sel(b_sel), .hazard_stall(hazard_stall),
    .ex_valid(ex_valid), .r1(r1), .r2(r2), .Imm(Imm), .PCp(PCp), .ALUOp(ALUOp),
    .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2), .b_control(b_control), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    id_valid = 0; id_r1 = 0; id_r2 = 0; id_imm = 0; id_pcp = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_aluop = 0;
    id_alusrc1 = 0; id_alusrc2 = 0; id_b_control = 0;
    id_regwrite = 0; id_memread = 0;
    exm_regwrite = 0; exm_rd = 0; exm_result = 0;
    mwb_regwrite = 0; mwb_rd = 0; mwb_result = 0;
    stall_in = 0; b_sel = 0;
  endtask

  task automatic drive_instr(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [4:0] rd, input logic rw,
                             input logic mr, input logic [2:0] bc);
    id_valid = 1; id_r1 = a; id_r2 = b; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_regwrite = rw; id_memread = mr; id_b_control = bc;
  endtask

  initial begin
    logic [31:0] stream [4];
    stream[0] = 32'h0000_0011; stream[1] = 32'h0000_0022;
    stream[2] = 32'h8000_0033; stream[3] = 32'hFFFF_FF44;

    drive_idle();
    rst = 1;

    // Reset held for two edges with a valid instruction at the inputs
    drive_instr(32'h0000_1234, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 3'b010);
    step();
    check("rst1_valid", {31'b0, ex_valid}, 32'd0);
    check("rst1_bctl", {29'b0, b_control}, 32'd0);
    check("rst1_r1", r1, 32'd0);
    step();
    check("rst2_valid", {31'b0, ex_valid}, 32'd0);
    check("rst2_regwrite", {31'b0, ex_regwrite}, 32'd0);
    check("rst2_memread", {31'b0, ex_memread}, 32'd0);
    rst = 0;
    step();
    check("post_rst_valid", {31'b0, ex_valid}, 32'd1);
    check("post_rst_r1", r1, 32'h0000_1234);
    check("post_rst_bctl", {29'b0, b_control}, 32'd2);

    // Plain capture
    drive_instr(32'hBABE_FACE, 32'hDEAD_BEEF, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 3'b000);
    id_imm = 32'h0000_0010; id_pcp = 32'h0000_0004; id_aluop = 4'b0000;
    id_alusrc1 = 1; id_alusrc2 = 1;
    step();
    check("cap_r1", r1, 32'hBABE_FACE);
    check("cap_r2", r2, 32'hDEAD_BEEF);
    check("cap_imm", Imm, 32'h0000_0010);
    check("cap_pcp", PCp, 32'h0000_0004);
    check("cap_aluop", {28'b0, ALUOp}, 32'd0);
    check("cap_src1", {31'b0, ALUSrc1}, 32'd1);
    check("cap_src2", {31'b0, ALUSrc2}, 32'd1);
    check("cap_valid", {31'b0, ex_valid}, 32'd1);

`ifdef IDEX_FWD_EN
    // Forwarding priority: EX/MEM, then MEM/WB, then register file
    drive_instr(32'hAAAA_0000, 32'h0000_0B0B, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 3'b000);
    exm_regwrite = 1; exm_rd = 5; exm_result = 32'h0000_000C;
    mwb_regwrite = 1; mwb_rd = 5; mwb_result = 32'h1111_1111;
    #1 check("fwd_no_stall", {31'b0, hazard_stall}, 32'd0);
    step();
    check("fwd_exm", r1, 32'h0000_000C);
    exm_regwrite = 0;
    step();
    check("fwd_mwb", r1, 32'h1111_1111);
    id_rs1 = 0;
    step();
    check("fwd_idx0", r1, 32'hAAAA_0000);
    id_rs2 = 5; exm_regwrite = 1;
    step();
    check("fwd_r2_exm", r2, 32'h0000_000C);
    exm_regwrite = 0; mwb_regwrite = 0; id_rs2 = 0;
`else
    // RAW against EX stalls once, then the re-presented instruction is captured
    drive_instr(32'h0, 32'h0, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 3'b000);
    step();
    check("raw_ex_rd", {27'b0, ex_rd}, 32'd9);
    drive_instr(32'h0, 32'h0000_0099, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0, 3'b000);
    #1 check("raw_ex_stall", {31'b0, hazard_stall}, 32'd1);
    step();
    check("raw_ex_bubble", {31'b0, ex_valid}, 32'd0);
    check("raw_ex_clear", {31'b0, hazard_stall}, 32'd0);
    step();
    check("raw_ex_cap", r2, 32'h0000_0099);
    // RAW against EX/MEM and MEM/WB
    drive_instr(32'h0000_0055, 32'h0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 3'b000);
    exm_regwrite = 1; exm_rd = 5;
    #1 check("raw_exm_stall", {31'b0, hazard_stall}, 32'd1);
    step();
    check("raw_exm_bubble", {31'b0, ex_valid}, 32'd0);
    exm_regwrite = 0; mwb_regwrite = 1; mwb_rd = 5;
    #1 check("raw_mwb_stall", {31'b0, hazard_stall}, 32'd1);
    mwb_rd = 0;
    #1 check("raw_idx0", {31'b0, hazard_stall}, 32'd0);
    mwb_regwrite = 0;
    step();
    check("raw_cap", r1, 32'h0000_0055);
`endif

    // Load-use: load rd=7, consumer reads rs2=7
    drive_instr(32'h0, 32'h0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 3'b000);
    step();
    check("lu_memread", {31'b0, ex_memread}, 32'd1);
    drive_instr(32'h0, 32'h0000_0077, 5'd0, 5'd7, 5'd8, 1'b1, 1'b0, 3'b000);
    #1 check("lu_stall", {31'b0, hazard_stall}, 32'd1);
    step();
    check("lu_bubble_valid", {31'b0, ex_valid}, 32'd0);
    check("lu_bubble_rw", {31'b0, ex_regwrite}, 32'd0);
    check("lu_released", {31'b0, hazard_stall}, 32'd0);
    step();
    check("lu_cap_valid", {31'b0, ex_valid}, 32'd1);
    check("lu_cap_r2", r2, 32'h0000_0077);
    check("lu_cap_rd", {27'b0, ex_rd}, 32'd8);

    // Load to x0 never hazards
    drive_instr(32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 3'b000);
    step();
    drive_instr(32'h0, 32'h0, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 3'b000);
    #1 check("lu_x0", {31'b0, hazard_stall}, 32'd0);

    // Flush beats hold
    drive_instr(32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 3'b010);
    step();
    check("bne_bctl", {29'b0, b_control}, 32'd2);
    b_sel = 1; stall_in = 1;
    step();
    check("flush_valid", {31'b0, ex_valid}, 32'd0);
    check("flush_bctl", {29'b0, b_control}, 32'd0);
    b_sel = 0; stall_in = 0;

    // Hold for three edges while ID inputs change
    drive_instr(32'hCAFE_0001, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 3'b001);
    id_aluop = 4'b0101;
    step();
    stall_in = 1;
    for (int i = 0; i < 3; i++) begin
      id_r1 = 32'h100 + i; id_aluop = 4'(i); id_b_control = 3'b100;
      step();
      check("hold_r1", r1, 32'hCAFE_0001);
      check("hold_aluop", {28'b0, ALUOp}, 32'd5);
      check("hold_bctl", {29'b0, b_control}, 32'd1);
      check("hold_valid", {31'b0, ex_valid}, 32'd1);
    end

    // Reset during a hold discards the held bundle
    rst = 1;
    step();
    check("rst_hold_valid", {31'b0, ex_valid}, 32'd0);
    check("rst_hold_r1", r1, 32'd0);
    rst = 0; stall_in = 0;

    // Back-to-back stream through an expected queue
    for (int i = 0; i < 4; i++) begin
      drive_instr(stream[i], ~stream[i], 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 3'b000);
      exp_q.push_back(stream[i]);
      step();
      check("stream_r1", r1, exp_q.pop_front());
      check("stream_r2", r2, ~stream[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
